// File: rtl/risc_toy_mem_wb.sv
// -----------------------------------------------------------------------------
// risc_toy_mem_wb
// MEM + WB back end of the RISC_TOY 5-stage pipeline. The EX result bundle is
// captured into the M stage every cycle (there is no stall). M drives the
// synchronous data-memory port. W writes the register file, and the load data
// arrives on DRDATA during the W cycle. The block also exports M-stage
// forwarding and load-use information, and counts retired instructions.
//
// Ports
//   CLK, RSTN            clock (rising edge) / asynchronous active-low reset
//   EX_VALID/OP/DEST     EX bundle control (EX_VALID=0 means bubble)
//   EX_RESULT/STDATA     ALU result or byte address / store data
//   DREQ/DRW/DADDR/DWDATA data-memory request driven from the M registers
//   DRDATA               load data, valid the cycle after a read request
//   RF_WEN/RF_WA/RF_DI   regfile write port; also the W forwarding source
//   FWD_M_VALID/DEST/DATA M-stage forwarding (non-load writers only)
//   LOAD_USE_M           M holds a load whose data is not yet available
//   RETIRE_CNT           wrapping count of valid instructions leaving W
// -----------------------------------------------------------------------------
module risc_toy_mem_wb #(
  parameter int AW       = 30,
  parameter int DW       = 32,
  parameter int RETIRE_W = 32
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic                EX_VALID,
  input  logic [4:0]          EX_OP,
  input  logic [4:0]          EX_DEST,
  input  logic [DW-1:0]       EX_RESULT,
  input  logic [DW-1:0]       EX_STDATA,
  output logic                DREQ,
  output logic                DRW,
  output logic [AW-1:0]       DADDR,
  output logic [DW-1:0]       DWDATA,
  input  logic [DW-1:0]       DRDATA,
  output logic                RF_WEN,
  output logic [4:0]          RF_WA,
  output logic [DW-1:0]       RF_DI,
  output logic                FWD_M_VALID,
  output logic [4:0]          FWD_M_DEST,
  output logic [DW-1:0]       FWD_M_DATA,
  output logic                LOAD_USE_M,
  output logic [RETIRE_W-1:0] RETIRE_CNT
);

  localparam logic [4:0] OP_ROR = 5'd14;
  localparam logic [4:0] OP_BRL = 5'd16;
  localparam logic [4:0] OP_JL  = 5'd18;
  localparam logic [4:0] OP_LD  = 5'd19;
  localparam logic [4:0] OP_LDR = 5'd20;
  localparam logic [4:0] OP_ST  = 5'd21;
  localparam logic [4:0] OP_STR = 5'd22;

  function automatic logic f_is_ld(input logic [4:0] op);
    case (op)
      OP_LD, OP_LDR: f_is_ld = 1'b1;
      default:       f_is_ld = 1'b0;
    endcase
  endfunction

  function automatic logic f_is_st(input logic [4:0] op);
    case (op)
      OP_ST, OP_STR: f_is_st = 1'b1;
      default:       f_is_st = 1'b0;
    endcase
  endfunction

  // ALU ops ADDI..ROR, the linking branches/jumps and the loads write a register.
  function automatic logic f_is_wr(input logic [4:0] op);
    case (op)
      OP_BRL, OP_JL, OP_LD, OP_LDR: f_is_wr = 1'b1;
      default:                      f_is_wr = (op <= OP_ROR);
    endcase
  endfunction

  // M-stage registers. Decoded flags are pre-qualified with EX_VALID and data is
  // zeroed for bubbles, so unknown EX values on a bubble never enter the pipe.
  logic          r_m_valid, r_m_ld, r_m_st, r_m_wr;
  logic [4:0]    r_m_dest;
  logic [DW-1:0] r_m_result, r_m_stdata;

  // W-stage registers
  logic          r_w_valid, r_w_ld, r_w_wr;
  logic [4:0]    r_w_dest;
  logic [DW-1:0] r_w_result;

  logic [RETIRE_W-1:0] r_retire_cnt;

  // EX -> M capture; reset drops any in-flight memory op immediately
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_m_valid  <= 1'b0;
      r_m_ld     <= 1'b0;
      r_m_st     <= 1'b0;
      r_m_wr     <= 1'b0;
      r_m_dest   <= 5'd0;
      r_m_result <= {DW{1'b0}};
      r_m_stdata <= {DW{1'b0}};
    end else begin
      r_m_valid  <= EX_VALID;
      r_m_ld     <= EX_VALID & f_is_ld(EX_OP);
      r_m_st     <= EX_VALID & f_is_st(EX_OP);
      r_m_wr     <= EX_VALID & f_is_wr(EX_OP);
      r_m_dest   <= EX_VALID ? EX_DEST : 5'd0;
      r_m_result <= EX_VALID ? EX_RESULT : {DW{1'b0}};
      r_m_stdata <= (EX_VALID & f_is_st(EX_OP)) ? EX_STDATA : {DW{1'b0}};
    end
  end

  // M -> W advance
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_w_valid  <= 1'b0;
      r_w_ld     <= 1'b0;
      r_w_wr     <= 1'b0;
      r_w_dest   <= 5'd0;
      r_w_result <= {DW{1'b0}};
    end else begin
      r_w_valid  <= r_m_valid;
      r_w_ld     <= r_m_ld;
      r_w_wr     <= r_m_wr;
      r_w_dest   <= r_m_dest;
      r_w_result <= r_m_result;
    end
  end

  // Retired-instruction counter; every valid W instruction counts, wraps naturally
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_retire_cnt <= {RETIRE_W{1'b0}};
    end else if (r_w_valid) begin
      r_retire_cnt <= r_retire_cnt + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end else begin
      r_retire_cnt <= r_retire_cnt;
    end
  end

  // Memory port and M forwarding: decoded purely from M registers
  always_comb begin
    DREQ        = r_m_ld | r_m_st;
    DRW         = r_m_st;
    DADDR       = r_m_result[AW+1:2];
    DWDATA      = r_m_stdata;
    FWD_M_VALID = r_m_wr & ~r_m_ld;
    LOAD_USE_M  = r_m_ld;
    if (r_m_wr & ~r_m_ld) begin
      FWD_M_DEST = r_m_dest;
      FWD_M_DATA = r_m_result;
    end else begin
      FWD_M_DEST = 5'd0;
      FWD_M_DATA = {DW{1'b0}};
    end
  end

  // Regfile write port; load data comes straight from the memory this cycle
  always_comb begin
    RF_WEN = r_w_wr;
    RF_WA  = 5'd0;
    RF_DI  = {DW{1'b0}};
    if (r_w_wr) begin
      RF_WA = r_w_dest;
      RF_DI = r_w_ld ? DRDATA : r_w_result;
    end else begin
      RF_WA = 5'd0;
      RF_DI = {DW{1'b0}};
    end
  end

  assign RETIRE_CNT = r_retire_cnt;

endmodule

// File: tb/tb_risc_toy_mem_wb.sv
// -----------------------------------------------------------------------------
// tb_risc_toy_mem_wb
// Directed bench for risc_toy_mem_wb. A small synchronous memory model answers
// the data port. A second instance with RETIRE_W=4 shares the stimulus so that
// the retire-counter wrap can be observed.
// -----------------------------------------------------------------------------
module tb_risc_toy_mem_wb;

  logic        CLK = 1'b0;
  logic        RSTN;
  logic        EX_VALID;
  logic [4:0]  EX_OP;
  logic [4:0]  EX_DEST;
  logic [31:0] EX_RESULT;
  logic [31:0] EX_STDATA;
  logic        DREQ, DRW;
  logic [29:0] DADDR;
  logic [31:0] DWDATA;
  logic [31:0] DRDATA;
  logic        RF_WEN;
  logic [4:0]  RF_WA;
  logic [31:0] RF_DI;
  logic        FWD_M_VALID;
  logic [4:0]  FWD_M_DEST;
  logic [31:0] FWD_M_DATA;
  logic        LOAD_USE_M;
  logic [31:0] RETIRE_CNT;

  // outputs of the narrow-counter instance
  logic        s4_dreq, s4_drw, s4_rf_wen, s4_fwd_v, s4_luse;
  logic [29:0] s4_daddr;
  logic [31:0] s4_dwdata, s4_rf_di, s4_fwd_data;
  logic [4:0]  s4_rf_wa, s4_fwd_dest;
  logic [3:0]  s4_cnt;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  risc_toy_mem_wb u_dut (
    .CLK(CLK), .RSTN(RSTN), .EX_VALID(EX_VALID), .EX_OP(EX_OP), .EX_DEST(EX_DEST),
    .EX_RESULT(EX_RESULT), .EX_STDATA(EX_STDATA), .DREQ(DREQ), .DRW(DRW),
    .DADDR(DADDR), .DWDATA(DWDATA), .DRDATA(DRDATA), .RF_WEN(RF_WEN),
    .RF_WA(RF_WA), .RF_DI(RF_DI), .FWD_M_VALID(FWD_M_VALID),
    .FWD_M_DEST(FWD_M_DEST), .FWD_M_DATA(FWD_M_DATA), .LOAD_USE_M(LOAD_USE_M),
    .RETIRE_CNT(RETIRE_CNT)
  );

  risc_toy_mem_wb #(.AW(30), .DW(32), .RETIRE_W(4)) u_dut4 (
    .CLK(CLK), .RSTN(RSTN), .EX_VALID(EX_VALID), .EX_OP(EX_OP), .EX_DEST(EX_DEST),
    .EX_RESULT(EX_RESULT), .EX_STDATA(EX_STDATA), .DREQ(s4_dreq), .DRW(s4_drw),
    .DADDR(s4_daddr), .DWDATA(s4_dwdata), .DRDATA(DRDATA), .RF_WEN(s4_rf_wen),
    .RF_WA(s4_rf_wa), .RF_DI(s4_rf_di), .FWD_M_VALID(s4_fwd_v),
    .FWD_M_DEST(s4_fwd_dest), .FWD_M_DATA(s4_fwd_data), .LOAD_USE_M(s4_luse),
    .RETIRE_CNT(s4_cnt)
  );

  // Synchronous memory model: writes commit at the edge, reads return next cycle
  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;
  logic [31:0] mem_rd   = 32'd0;
  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[8'h81] <= 32'hCAFEF00D;
      mem_init   <= 1'b1;
    end else if (DREQ && DRW) begin
      mem[DADDR[7:0]] <= DWDATA;
    end else if (DREQ && !DRW) begin
      mem_rd <= mem[DADDR[7:0]];
    end
  end
  assign DRDATA = mem_rd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] d,
                       input logic [31:0] res, input logic [31:0] sd);
    EX_VALID  = v;
    EX_OP     = op;
    EX_DEST   = d;
    EX_RESULT = res;
    EX_STDATA = sd;
  endtask

  task automatic bubble();
    drive(1'b0, 5'bx, 5'bx, 32'bx, 32'bx);
  endtask

  initial begin
    RSTN = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    #12;
    chk("rst_dreq", DREQ, 1'b0);
    chk("rst_rfwen", RF_WEN, 1'b0);
    chk("rst_fwdv", FWD_M_VALID, 1'b0);
    chk("rst_cnt", RETIRE_CNT, 32'd0);
    tick();
    RSTN = 1'b1;
    tick();

    // 1: ALU op writing r3
    drive(1'b1, 5'd1, 5'd3, 32'h12345678, 32'd0);
    tick();
    chk("t1_dreq_m", DREQ, 1'b0);
    chk("t1_fwdv", FWD_M_VALID, 1'b1);
    chk("t1_fwdd", FWD_M_DEST, 5'd3);
    chk("t1_fwddata", FWD_M_DATA, 32'h12345678);
    chk("t1_luse", LOAD_USE_M, 1'b0);
    bubble();
    tick();
    chk("t1_dreq_w", DREQ, 1'b0);
    chk("t1_wen", RF_WEN, 1'b1);
    chk("t1_wa", RF_WA, 5'd3);
    chk("t1_di", RF_DI, 32'h12345678);
    tick();
    chk("t1_cnt", RETIRE_CNT, 32'd1);

    // 2: ST 0xDEADBEEF to byte 0x100
    drive(1'b1, 5'd21, 5'd2, 32'h100, 32'hDEADBEEF);
    tick();
    chk("t2_dreq", DREQ, 1'b1);
    chk("t2_drw", DRW, 1'b1);
    chk("t2_daddr", DADDR, 30'h40);
    chk("t2_dwdata", DWDATA, 32'hDEADBEEF);
    chk("t2_fwdv", FWD_M_VALID, 1'b0);
    bubble();
    tick();
    chk("t2_wen", RF_WEN, 1'b0);
    chk("t2_wa0", RF_WA, 5'd0);
    chk("t2_di0", RF_DI, 32'd0);
    tick();
    chk("t2_cnt", RETIRE_CNT, 32'd2);

    // 3: LD r5 from byte 0x204
    drive(1'b1, 5'd19, 5'd5, 32'h204, 32'd0);
    tick();
    chk("t3_dreq", DREQ, 1'b1);
    chk("t3_drw", DRW, 1'b0);
    chk("t3_daddr", DADDR, 30'h81);
    chk("t3_dwdata", DWDATA, 32'd0);
    chk("t3_luse", LOAD_USE_M, 1'b1);
    chk("t3_fwdv", FWD_M_VALID, 1'b0);
    chk("t3_fwdd", FWD_M_DEST, 5'd0);
    bubble();
    tick();
    chk("t3_wen", RF_WEN, 1'b1);
    chk("t3_wa", RF_WA, 5'd5);
    chk("t3_di", RF_DI, 32'hCAFEF00D);
    tick();
    chk("t3_cnt", RETIRE_CNT, 32'd3);

    // 4: ST 0x55 @word 0x40, then LDR r7 from the same word back-to-back
    drive(1'b1, 5'd21, 5'd0, 32'h100, 32'h55);
    tick();
    chk("t4_dreq0", DREQ, 1'b1);
    chk("t4_drw0", DRW, 1'b1);
    drive(1'b1, 5'd20, 5'd7, 32'h100, 32'd0);
    tick();
    chk("t4_dreq1", DREQ, 1'b1);
    chk("t4_drw1", DRW, 1'b0);
    chk("t4_daddr1", DADDR, 30'h40);
    chk("t4_wen_st", RF_WEN, 1'b0);
    bubble();
    tick();
    chk("t4_wen", RF_WEN, 1'b1);
    chk("t4_wa", RF_WA, 5'd7);
    chk("t4_di", RF_DI, 32'h55);
    tick();
    chk("t4_cnt", RETIRE_CNT, 32'd5);

    // 5: BR, J, bubble, JL r31 -- only JL writes
    drive(1'b1, 5'd15, 5'd1, 32'h111, 32'd0);
    tick();
    chk("t5_br_dreq", DREQ, 1'b0);
    chk("t5_br_fwdv", FWD_M_VALID, 1'b0);
    drive(1'b1, 5'd17, 5'd2, 32'h222, 32'd0);
    tick();
    chk("t5_br_wen", RF_WEN, 1'b0);
    bubble();
    tick();
    chk("t5_j_wen", RF_WEN, 1'b0);
    drive(1'b1, 5'd18, 5'd31, 32'h1000, 32'd0);
    tick();
    chk("t5_bub_wen", RF_WEN, 1'b0);
    chk("t5_jl_fwdv", FWD_M_VALID, 1'b1);
    bubble();
    tick();
    chk("t5_jl_wen", RF_WEN, 1'b1);
    chk("t5_jl_wa", RF_WA, 5'd31);
    chk("t5_jl_di", RF_DI, 32'h1000);
    tick();
    chk("t5_cnt", RETIRE_CNT, 32'd8);
    chk("t5_cnt4", s4_cnt, 4'd8);

    // 6: reset while a load sits in M
    drive(1'b1, 5'd19, 5'd9, 32'h204, 32'd0);
    tick();
    chk("t6_dreq_pre", DREQ, 1'b1);
    bubble();
    #2;
    RSTN = 1'b0;
    #1;
    chk("t6_dreq", DREQ, 1'b0);
    chk("t6_luse", LOAD_USE_M, 1'b0);
    chk("t6_wen", RF_WEN, 1'b0);
    chk("t6_cnt", RETIRE_CNT, 32'd0);
    tick();
    RSTN = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 32'd0, 32'd0);
    tick();
    chk("t6_wen_a", RF_WEN, 1'b0);
    tick();
    chk("t6_wen_b", RF_WEN, 1'b0);
    chk("t6_cnt_b", RETIRE_CNT, 32'd0);

    // 7: 16 retirements wrap the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 5'd2, 5'd4, i, 32'd0);
      tick();
    end
    bubble();
    tick();
    chk("t7_cnt4_15", s4_cnt, 4'd15);
    chk("t7_cnt_15", RETIRE_CNT, 32'd15);
    tick();
    chk("t7_cnt4_wrap", s4_cnt, 4'd0);
    chk("t7_cnt_16", RETIRE_CNT, 32'd16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
